// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-stage access unit: FSM states, funct3
// encodings for loads/stores, and the access legality check.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } mau_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    // Stores only exist for sizes 000..010, so the unsigned load encodings fault as stores.
    function automatic logic access_fault(input logic [2:0] funct3,
                                          input logic [1:0] byte_off,
                                          input logic       is_store);
        logic f;
        case (funct3)
            F3_LB:   f = 1'b0;
            F3_LH:   f = byte_off[0];
            F3_LW:   f = (byte_off != 2'b00);
            F3_LBU:  f = is_store;
            F3_LHU:  f = is_store | byte_off[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (byte_off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data bus master: one load or store per request, stalling the
// pipeline until the bus handshake completes; misaligned/illegal accesses fault.
module mem_access_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_resultM,
    input  logic [31:0] write_dataM,
    input  logic [2:0]  funct3M,
    input  logic [1:0]  result_srcM,
    input  logic        mem_write_enM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] read_dataM,
    output logic        stallM,
    output logic        misaligned_excM
);

    mau_state_e state, state_next;

    logic        is_store;
    logic        pending;
    logic        fault;
    logic        legal;

    logic [29:0] addr_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] read_q;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ext_data;

    assign is_store = mem_write_enM;
    assign pending  = mem_write_enM | (result_srcM == RESULT_SRC_MEM);
    assign fault    = pending & access_fault(funct3M, alu_resultM[1:0], is_store);
    assign legal    = pending & ~fault;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = write_dataM;
        case (funct3M)
            F3_SB: begin
                st_be    = 4'b0001 << alu_resultM[1:0];
                st_wdata = {4{write_dataM[7:0]}};
            end
            F3_SH: begin
                st_be    = 4'b0011 << alu_resultM[1:0];
                st_wdata = {2{write_dataM[15:0]}};
            end
            F3_SW: begin
                st_be    = 4'b1111;
                st_wdata = write_dataM;
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = write_dataM;
            end
        endcase
    end

    load_extend u_load_extend (
        .rdata    (dmem_rdata),
        .funct3   (funct3_q),
        .byte_off (off_q),
        .data     (ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (legal)       state_next = REQ;
            REQ:  if (dmem_ready)  state_next = we_q ? DONE : WAIT;
            WAIT: if (dmem_rvalid) state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_comb begin
        dmem_req        = (state == REQ);
        dmem_we         = (state == REQ) & we_q;
        stallM          = ((state == IDLE) & legal) | (state == REQ) | (state == WAIT);
        misaligned_excM = (state == IDLE) & fault;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            off_q    <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            read_q   <= '0;
        end else begin
            if (state == IDLE && legal) begin
                addr_q   <= alu_resultM[31:2];
                off_q    <= alu_resultM[1:0];
                funct3_q <= funct3M;
                we_q     <= is_store;
                be_q     <= is_store ? st_be : 4'b1111;
                wdata_q  <= is_store ? st_wdata : '0;
            end
            if (state == WAIT && dmem_rvalid) begin
                read_q <= ext_data;
            end
        end
    end

    assign dmem_addr  = {addr_q, 2'b00};
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign read_dataM = read_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic [31:0] alu_resultM;
    logic [31:0] write_dataM;
    logic [2:0]  funct3M;
    logic [1:0]  result_srcM;
    logic        mem_write_enM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] read_dataM;
    logic        stallM;
    logic        misaligned_excM;

    int unsigned vectors;
    int unsigned miscompares;

    mem_access_unit dut (
        .clk             (clk),
        .reset           (reset),
        .alu_resultM     (alu_resultM),
        .write_dataM     (write_dataM),
        .funct3M         (funct3M),
        .result_srcM     (result_srcM),
        .mem_write_enM   (mem_write_enM),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_ready      (dmem_ready),
        .dmem_rvalid     (dmem_rvalid),
        .dmem_rdata      (dmem_rdata),
        .read_dataM      (read_dataM),
        .stallM          (stallM),
        .misaligned_excM (misaligned_excM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        alu_resultM   = '0;
        write_dataM   = '0;
        funct3M       = '0;
        result_srcM   = 2'b00;
        mem_write_enM = 1'b0;
        dmem_ready    = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = '0;
    endtask

    // Store with ready on the first REQ cycle; rs lets a load request ride along.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] f3, input logic [1:0] rs,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        alu_resultM = addr; write_dataM = data; funct3M = f3;
        result_srcM = rs; mem_write_enM = 1'b1; dmem_ready = 1'b1;
        #1;
        chk({tag, "_idle_stall"}, {31'b0, stallM}, 32'd1);
        chk({tag, "_idle_exc"}, {31'b0, misaligned_excM}, 32'd0);
        tick();
        chk({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
        chk({tag, "_we"}, {31'b0, dmem_we}, 32'd1);
        chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, {28'b0, dmem_be}, {28'b0, exp_be});
        chk({tag, "_wdata"}, dmem_wdata, exp_wd);
        chk({tag, "_req_stall"}, {31'b0, stallM}, 32'd1);
        tick();
        chk({tag, "_done_stall"}, {31'b0, stallM}, 32'd0);
        chk({tag, "_done_req"}, {31'b0, dmem_req}, 32'd0);
        clear_inputs();
        tick();
    endtask

    // Load with ready on the first REQ cycle and rvalid on the first WAIT cycle.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp);
        alu_resultM = addr; funct3M = f3; result_srcM = 2'b01;
        mem_write_enM = 1'b0; dmem_ready = 1'b1;
        #1;
        chk({tag, "_idle_stall"}, {31'b0, stallM}, 32'd1);
        tick();
        chk({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
        chk({tag, "_we"}, {31'b0, dmem_we}, 32'd0);
        chk({tag, "_be"}, {28'b0, dmem_be}, 32'hF);
        chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        #1;
        chk({tag, "_wait_stall"}, {31'b0, stallM}, 32'd1);
        chk({tag, "_wait_req"}, {31'b0, dmem_req}, 32'd0);
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = 32'h5A5A5A5A;
        chk({tag, "_data"}, read_dataM, exp);
        chk({tag, "_done_stall"}, {31'b0, stallM}, 32'd0);
        clear_inputs();
        tick();
        chk({tag, "_hold"}, read_dataM, exp);
    endtask

    typedef struct {
        string      tag;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        we;
        logic [1:0]  rs;
    } fault_vec_t;

    fault_vec_t faults[5];

    initial begin
        vectors = 0;
        miscompares = 0;
        clear_inputs();
        reset = 1'b0;

        // Reset state
        #2;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_rdata", read_dataM, 32'd0);
        chk("rst_stall", {31'b0, stallM}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // SW addr 0x100, two stall cycles
        do_store("sw", 32'h100, 32'hDEADBEEF, 3'b010, 2'b00, 4'b1111, 32'hDEADBEEF);

        // SH with load request also set: store wins
        do_store("sh_prio", 32'h102, 32'h0000CAFE, 3'b001, 2'b01, 4'b1100, 32'hCAFECAFE);

        // SB addr 0x7 with ready low for three REQ cycles
        alu_resultM = 32'h7; write_dataM = 32'h000000AB; funct3M = 3'b000;
        mem_write_enM = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("sb_idle_stall", {31'b0, stallM}, 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sb_hold_req", {31'b0, dmem_req}, 32'd1);
            chk("sb_hold_addr", dmem_addr, 32'h4);
            chk("sb_hold_be", {28'b0, dmem_be}, 32'h8);
            chk("sb_hold_wdata", dmem_wdata, 32'hABABABAB);
            chk("sb_hold_stall", {31'b0, stallM}, 32'd1);
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        chk("sb_req4", {31'b0, dmem_req}, 32'd1);
        tick();
        chk("sb_done_stall", {31'b0, stallM}, 32'd0);
        chk("sb_done_req", {31'b0, dmem_req}, 32'd0);
        clear_inputs();
        tick();

        // LB addr 0x203, rvalid two cycles after ready: four stall cycles
        alu_resultM = 32'h203; funct3M = 3'b000; result_srcM = 2'b01; dmem_ready = 1'b1;
        #1;
        chk("lb_stall1", {31'b0, stallM}, 32'd1);
        tick();
        chk("lb_req", {31'b0, dmem_req}, 32'd1);
        chk("lb_stall2", {31'b0, stallM}, 32'd1);
        tick();
        chk("lb_stall3", {31'b0, stallM}, 32'd1);
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80123456;
        #1;
        chk("lb_stall4", {31'b0, stallM}, 32'd1);
        tick();
        dmem_rvalid = 1'b0;
        chk("lb_done_stall", {31'b0, stallM}, 32'd0);
        chk("lb_data", read_dataM, 32'hFFFFFF80);
        clear_inputs();
        tick();

        do_load("lhu", 32'h202, 3'b101, 32'hBEEF1234, 32'h0000BEEF);
        do_load("lh",  32'h200, 3'b001, 32'h1234F00D, 32'hFFFFF00D);
        do_load("lbu", 32'h201, 3'b100, 32'h00009A00, 32'h0000009A);
        do_load("lw",  32'h300, 3'b010, 32'hCAFEF00D, 32'hCAFEF00D);

        // Faulting accesses: exception same cycle, no request, no stall
        faults[0] = '{"f_sh_odd",   32'h101, 3'b001, 1'b1, 2'b00};
        faults[1] = '{"f_lw_mis",   32'h102, 3'b010, 1'b0, 2'b01};
        faults[2] = '{"f_ill_011",  32'h100, 3'b011, 1'b0, 2'b01};
        faults[3] = '{"f_st_100",   32'h100, 3'b100, 1'b1, 2'b01};
        faults[4] = '{"f_lhu_odd",  32'h203, 3'b101, 1'b0, 2'b01};
        foreach (faults[k]) begin
            alu_resultM = faults[k].addr; funct3M = faults[k].f3;
            mem_write_enM = faults[k].we; result_srcM = faults[k].rs; dmem_ready = 1'b1;
            #1;
            chk({faults[k].tag, "_exc"}, {31'b0, misaligned_excM}, 32'd1);
            chk({faults[k].tag, "_stall"}, {31'b0, stallM}, 32'd0);
            chk({faults[k].tag, "_req"}, {31'b0, dmem_req}, 32'd0);
            tick();
            chk({faults[k].tag, "_req_next"}, {31'b0, dmem_req}, 32'd0);
            chk({faults[k].tag, "_exc_next"}, {31'b0, misaligned_excM}, 32'd1);
            clear_inputs();
            #1;
            chk({faults[k].tag, "_exc_clr"}, {31'b0, misaligned_excM}, 32'd0);
            tick();
        end

        // Reset during WAIT abandons the load; a late rvalid is discarded
        alu_resultM = 32'h400; funct3M = 3'b010; result_srcM = 2'b01; dmem_ready = 1'b1;
        tick();
        chk("rw_req", {31'b0, dmem_req}, 32'd1);
        tick();
        chk("rw_wait_stall", {31'b0, stallM}, 32'd1);
        clear_inputs();
        reset = 1'b0;
        #1;
        chk("rw_rst_rdata", read_dataM, 32'd0);
        chk("rw_rst_addr", dmem_addr, 32'd0);
        chk("rw_rst_stall", {31'b0, stallM}, 32'd0);
        tick();
        reset = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        tick();
        dmem_rvalid = 1'b0;
        chk("rw_late_rdata", read_dataM, 32'd0);
        chk("rw_late_stall", {31'b0, stallM}, 32'd0);
        chk("rw_late_req", {31'b0, dmem_req}, 32'd0);
        tick();
        chk("rw_after_rdata", read_dataM, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL use one clock (`clk`) and an asynchronous, active-low reset (`reset`).
REQ-002 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  async active-low reset
- alu_resultM  in  32  byte address
- write_dataM  in  32  store data
- funct3M  in  3  access size/sign
- result_srcM  in  2  01 = load
- mem_write_enM  in  1  store
- dmem_req  out  1  bus request
- dmem_we  out  1  write
- dmem_addr  out  32  word address, [1:0]=0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned data
- dmem_ready  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- read_dataM  out  32  extended load result
- stallM  out  1  hold IF..M
- misaligned_excM  out  1  alignment/encoding fault

Function
REQ-003 An access SHALL be pending when mem_write_enM=1 or result_srcM=01; a store SHALL take priority if both are set.
REQ-004 The FSM SHALL have the states IDLE, REQ, WAIT, DONE.
REQ-005 IDLE: a legal pending access SHALL register addr/be/wdata/we and go to REQ; otherwise the FSM SHALL stay in IDLE.
REQ-006 REQ: dmem_req=1 with stable outputs; on dmem_ready a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-007 WAIT: on dmem_rvalid the block SHALL capture dmem_rdata and go to DONE; dmem_rvalid SHALL be ignored in every other state.
REQ-008 DONE: one cycle, then IDLE unconditionally.
REQ-009 stallM SHALL be combinational and equal 1 when (state=IDLE and legal pending access) or state is REQ or WAIT; it SHALL be 0 in DONE.
REQ-010 Minimum latency: store 2 cycles of stall (IDLE, REQ with ready=1); load 3 cycles (rvalid on the first WAIT cycle).
REQ-011 Store lanes: SB gives be=0001<<addr[1:0] with the byte replicated x4; SH gives be=0011<<addr[1:0] with the half replicated x2; SW gives be=1111.
REQ-012 Loads SHALL assert dmem_be=1111 and select the lane by the registered addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-013 read_dataM SHALL be valid in DONE, hold its value until the next capture, and reset to 0.
REQ-014 A fault SHALL be raised for LH/LHU/SH with addr[0]=1, for LW/SW with addr[1:0]≠00, and for funct3 ∈ {011,110,111} or store funct3 >010.
REQ-015 On a fault in IDLE: misaligned_excM=1 in that same cycle (combinational), no bus request, stallM=0, and the FSM SHALL stay in IDLE.
REQ-016 dmem_addr SHALL equal {alu_resultM[31:2],2'b00}.

Reset
REQ-017 Asserting reset SHALL force the following immediately, independent of clk: state=IDLE; dmem_req, dmem_we=0; dmem_be=0; dmem_addr, dmem_wdata, read_dataM=0.
REQ-018 Reset in REQ or WAIT SHALL abandon the transaction; a later dmem_rvalid SHALL be discarded.

Structure
REQ-019 Shared package cpu_pkg SHALL hold:
- the FSM state enum
- funct3 encodings (LB..LHU, SB..SW)
- RESULT_SRC_MEM=2'b01
REQ-020 Lane select and extension SHALL be the combinational sub-module load_extend.

Verification
REQ-021 SW addr 0x100, data 0xDEADBEEF, ready=1 first cycle -> dmem_addr 0x100, be 1111, stallM high for 2 cycles.
REQ-022 LB addr 0x203, rdata 0x80xxxxxx, rvalid 2 cycles after ready -> stallM for 4 cycles, read_dataM 0xFFFFFF80.
REQ-023 LHU addr 0x202, rdata 0xBEEF1234 -> read_dataM 0x0000BEEF.
REQ-024 SH addr 0x101 -> misaligned_excM=1 same cycle, dmem_req never asserted, stallM=0.
REQ-025 Load with reset asserted during WAIT, then rvalid after release -> state IDLE, read_dataM 0, no stall.
REQ-026 SB addr 0x7 data 0x000000AB, ready held low 3 cycles -> dmem_req and outputs stable, be 1000, wdata 0xABABABAB.
